// File: rtl/opb_reg_pkg.sv
// rtl/opb_reg_pkg.sv - shared types and constants for the OPB software registers
package opb_reg_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACK  = 2'd1,
        WAIT = 2'd2
    } state_t;

    localparam logic [31:0] DATA_OFF     = 32'h0000_0000;
    localparam logic [31:0] STAT_OFF     = 32'h0000_0004;
    localparam int          STAT_NEW_BIT = 31;
    localparam int          OVR_W        = 16;

    function automatic logic [31:0] status_word(input logic new_flag,
                                                input logic [OVR_W-1:0] ovr_cnt);
        logic [31:0] w;
        w                = '0;
        w[STAT_NEW_BIT]  = new_flag;
        w[OVR_W-1:0]     = ovr_cnt;
        return w;
    endfunction

endpackage

// File: rtl/opb_slave_ack_fsm.sv
// rtl/opb_slave_ack_fsm.sv - OPB window decode and single-ack handshake FSM
module opb_slave_ack_fsm
    import opb_reg_pkg::*;
#(
    parameter int                      C_OPB_AWIDTH = 32,
    parameter logic [C_OPB_AWIDTH-1:0] C_BASEADDR   = 32'h0100_C300,
    parameter logic [C_OPB_AWIDTH-1:0] C_HIGHADDR   = 32'h0100_C3FF
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic [0:C_OPB_AWIDTH-1] i_abus,
    input  logic                    i_select,
    input  logic                    i_rnw,
    output logic                    o_rd_stb,
    output logic                    o_wr_stb,
    output logic [C_OPB_AWIDTH-1:0] o_offset,
    output logic                    o_xfer_ack
);

    state_t r_state;
    logic   r_xfer_ack;
    logic   w_hit;
    logic   w_take;

    assign w_hit    = i_select && (i_abus >= C_BASEADDR) && (i_abus <= C_HIGHADDR);
    assign w_take   = (r_state == IDLE) && w_hit;
    assign o_offset = i_abus - C_BASEADDR;

    // Strobes mark the sampling cycle; the ack and any side effects follow one cycle later.
    assign o_rd_stb   = w_take && i_rnw;
    assign o_wr_stb   = w_take && !i_rnw;
    assign o_xfer_ack = r_xfer_ack;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= IDLE;
            r_xfer_ack <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_xfer_ack <= w_hit;
                    if (w_hit) r_state <= ACK;
                end
                ACK: begin
                    r_xfer_ack <= 1'b0;
                    r_state    <= WAIT;
                end
                WAIT: begin
                    r_xfer_ack <= 1'b0;
                    if (!i_select) r_state <= IDLE;
                end
                default: begin
                    r_xfer_ack <= 1'b0;
                    r_state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/opb_register_simulink2ppc.sv
// rtl/opb_register_simulink2ppc.sv - fabric-to-PPC read register with new flag and overrun count
module opb_register_simulink2ppc
    import opb_reg_pkg::*;
#(
    parameter int                      C_OPB_AWIDTH = 32,
    parameter int                      C_OPB_DWIDTH = 32,
    parameter logic [C_OPB_AWIDTH-1:0] C_BASEADDR   = 32'h0100_C300,
    parameter logic [C_OPB_AWIDTH-1:0] C_HIGHADDR   = 32'h0100_C3FF,
    parameter logic [63:0]             C_FAMILY     = "virtex6"
) (
    input  logic                    OPB_Clk,
    input  logic                    OPB_Rst,
    input  logic [0:C_OPB_AWIDTH-1] OPB_ABus,
    input  logic [0:3]              OPB_BE,
    input  logic [0:C_OPB_DWIDTH-1] OPB_DBus,
    input  logic                    OPB_RNW,
    input  logic                    OPB_select,
    input  logic                    OPB_seqAddr,
    output logic [0:C_OPB_DWIDTH-1] Sl_DBus,
    output logic                    Sl_xferAck,
    output logic                    Sl_errAck,
    output logic                    Sl_retry,
    output logic                    Sl_toutSup,
    input  logic [31:0]             user_data_in,
    input  logic                    user_valid
);

    logic                    w_rd_stb;
    logic                    w_wr_stb;
    logic [C_OPB_AWIDTH-1:0] w_offset;
    logic                    w_xfer_ack;
    logic [31:0]             w_status;
    logic [31:0]             w_rd_mux;
    logic                    w_unused;

    logic [31:0]             r_data_reg;
    logic                    r_new_flag;
    logic [OVR_W-1:0]        r_ovr_cnt;
    logic [31:0]             r_rd_word;
    logic                    r_clr_new;
    logic                    r_clr_ovr;

    opb_slave_ack_fsm #(
        .C_OPB_AWIDTH (C_OPB_AWIDTH),
        .C_BASEADDR   (C_BASEADDR),
        .C_HIGHADDR   (C_HIGHADDR)
    ) u_ack_fsm (
        .i_clk      (OPB_Clk),
        .i_rst      (OPB_Rst),
        .i_abus     (OPB_ABus),
        .i_select   (OPB_select),
        .i_rnw      (OPB_RNW),
        .o_rd_stb   (w_rd_stb),
        .o_wr_stb   (w_wr_stb),
        .o_offset   (w_offset),
        .o_xfer_ack (w_xfer_ack)
    );

    assign w_unused = ^{OPB_seqAddr, OPB_DBus, C_FAMILY};
    assign w_status = status_word(r_new_flag, r_ovr_cnt);

    always_comb begin
        w_rd_mux = '0;
        if (w_offset == DATA_OFF)      w_rd_mux = r_data_reg;
        else if (w_offset == STAT_OFF) w_rd_mux = w_status;
    end

    // Read word and side-effect requests are registered at the sampling edge so they line up with the ack cycle.
    always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
        if (OPB_Rst) begin
            r_rd_word <= '0;
            r_clr_new <= 1'b0;
            r_clr_ovr <= 1'b0;
        end else begin
            r_rd_word <= w_rd_stb ? w_rd_mux : '0;
            r_clr_new <= w_rd_stb && (w_offset == DATA_OFF);
            r_clr_ovr <= w_wr_stb && (w_offset == STAT_OFF) && (|OPB_BE);
        end
    end

    // A capture always wins over a same-cycle flag clear; overruns are not counted when software is clearing.
    always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
        if (OPB_Rst) begin
            r_data_reg <= '0;
            r_new_flag <= 1'b0;
            r_ovr_cnt  <= '0;
        end else begin
            if (user_valid) begin
                r_data_reg <= user_data_in;
                r_new_flag <= 1'b1;
            end else if (r_clr_new) begin
                r_new_flag <= 1'b0;
            end

            if (r_clr_ovr) begin
                r_ovr_cnt <= '0;
            end else if (user_valid && r_new_flag && !r_clr_new && (r_ovr_cnt != '1)) begin
                r_ovr_cnt <= r_ovr_cnt + 1'b1;
            end
        end
    end

    assign Sl_DBus    = r_rd_word;
    assign Sl_xferAck = w_xfer_ack;
    assign Sl_errAck  = 1'b0;
    assign Sl_retry   = 1'b0;
    assign Sl_toutSup = 1'b0;

endmodule

// File: tb/tb_opb_register_simulink2ppc.sv
// tb/tb_opb_register_simulink2ppc.sv - directed scoreboard bench for opb_register_simulink2ppc
module tb_opb_register_simulink2ppc;

    localparam logic [31:0] A_DATA = 32'h0100_C300;
    localparam logic [31:0] A_STAT = 32'h0100_C304;
    localparam logic [31:0] A_OTHR = 32'h0100_C308;
    localparam logic [31:0] A_OOW  = 32'h0100_C400;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [0:31] abus = '0;
    logic [0:3]  be = '0;
    logic [0:31] dbus_w = '0;
    logic        rnw = 1'b0;
    logic        sel = 1'b0;
    logic        seq = 1'b0;
    logic [0:31] sl_dbus;
    logic        sl_ack;
    logic        sl_err;
    logic        sl_retry;
    logic        sl_tout;
    logic [31:0] udata = '0;
    logic        uvalid = 1'b0;

    int          checks = 0;
    int          failures = 0;
    logic        mon_en = 1'b0;
    logic [31:0] exp_q[$];

    opb_register_simulink2ppc dut (
        .OPB_Clk      (clk),
        .OPB_Rst      (rst),
        .OPB_ABus     (abus),
        .OPB_BE       (be),
        .OPB_DBus     (dbus_w),
        .OPB_RNW      (rnw),
        .OPB_select   (sel),
        .OPB_seqAddr  (seq),
        .Sl_DBus      (sl_dbus),
        .Sl_xferAck   (sl_ack),
        .Sl_errAck    (sl_err),
        .Sl_retry     (sl_retry),
        .Sl_toutSup   (sl_tout),
        .user_data_in (udata),
        .user_valid   (uvalid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en && !rst && !sl_ack) check("dbus_idle_zero", sl_dbus, 32'h0);
        if (mon_en) check("tied_outputs", {29'h0, sl_err, sl_retry, sl_tout}, 32'h0);
    end

    // Waits up to four cycles for the ack; returns its latency in cycles, or 0 if no ack arrives.
    task automatic wait_ack(output int lat);
        lat = 0;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            if (sl_ack) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [31:0] exp, input string tag);
        int lat;
        exp_q.push_back(exp);
        @(negedge clk);
        sel = 1'b1; rnw = 1'b1; abus = addr; be = 4'hF;
        wait_ack(lat);
        check({tag, "_ack_latency"}, lat, 1);
        if (lat != 0) check(tag, sl_dbus, exp_q.pop_front());
        else void'(exp_q.pop_front());
        sel = 1'b0;
        @(negedge clk);
        check({tag, "_ack_drop"}, {31'h0, sl_ack}, 32'h0);
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [3:0] be_v,
                            input logic [31:0] data, input string tag);
        int lat;
        @(negedge clk);
        sel = 1'b1; rnw = 1'b0; abus = addr; be = be_v; dbus_w = data;
        wait_ack(lat);
        check({tag, "_ack_latency"}, lat, 1);
        sel = 1'b0;
        @(negedge clk);
    endtask

    task automatic capture(input logic [31:0] d);
        @(negedge clk);
        uvalid = 1'b1; udata = d;
        @(negedge clk);
        uvalid = 1'b0;
    endtask

    initial begin
        int acks;
        int lat;

        repeat (3) @(negedge clk);
        check("reset_ack", {31'h0, sl_ack}, 32'h0);
        check("reset_dbus", sl_dbus, 32'h0);
        rst = 1'b0;
        mon_en = 1'b1;

        do_read(A_STAT, 32'h0000_0000, "rst_status");
        do_read(A_DATA, 32'h0000_0000, "rst_data");

        capture(32'hDEAD_BEEF);
        do_read(A_DATA, 32'hDEAD_BEEF, "data_deadbeef");
        do_read(A_STAT, 32'h0000_0000, "status_after_read");

        @(negedge clk);
        uvalid = 1'b1; udata = 32'h11;
        @(negedge clk); udata = 32'h22;
        @(negedge clk); udata = 32'h33;
        @(negedge clk); uvalid = 1'b0;
        do_read(A_STAT, 32'h8000_0002, "status_three_caps");
        do_write(A_STAT, 4'h0, 32'hFFFF_FFFF, "wr_status_be0");
        do_read(A_STAT, 32'h8000_0002, "status_be0_kept");
        do_write(A_STAT, 4'hF, 32'hFFFF_FFFF, "wr_status_bef");
        do_read(A_STAT, 32'h8000_0000, "status_cleared");

        // Capture lands in the ack cycle of a DATA read.
        exp_q.push_back(32'h0000_0033);
        @(negedge clk);
        sel = 1'b1; rnw = 1'b1; abus = A_DATA; be = 4'hF;
        wait_ack(lat);
        check("race_ack_latency", lat, 1);
        if (lat != 0) check("race_old_data", sl_dbus, exp_q.pop_front());
        else void'(exp_q.pop_front());
        uvalid = 1'b1; udata = 32'hCAFE_F00D; sel = 1'b0;
        @(negedge clk);
        uvalid = 1'b0;
        do_read(A_STAT, 32'h8000_0000, "race_status");
        do_read(A_DATA, 32'hCAFE_F00D, "race_new_data");
        do_read(A_STAT, 32'h0000_0000, "race_status_clr");

        exp_q.push_back(32'h0000_0000);
        @(negedge clk);
        sel = 1'b1; rnw = 1'b1; abus = A_STAT; be = 4'hF;
        acks = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (sl_ack) begin
                acks++;
                check("hold_sel_data", sl_dbus, exp_q.pop_front());
            end
        end
        check("hold_sel_one_ack", acks, 1);
        if (acks == 0) void'(exp_q.pop_front());
        sel = 1'b0;
        @(negedge clk);

        @(negedge clk);
        sel = 1'b1; rnw = 1'b1; abus = A_OOW; be = 4'hF;
        wait_ack(lat);
        check("oow_no_ack", lat, 0);
        check("oow_dbus", sl_dbus, 32'h0);
        sel = 1'b0;
        @(negedge clk);

        do_read(A_OTHR, 32'h0000_0000, "other_offset");
        do_write(A_DATA, 4'hF, 32'h1234_5678, "wr_data");
        do_read(A_STAT, 32'h0000_0000, "status_after_wr_data");
        do_read(A_DATA, 32'hCAFE_F00D, "data_after_wr_data");

        @(negedge clk);
        uvalid = 1'b1;
        for (int i = 0; i < 32'h10005; i++) begin
            udata = i;
            @(negedge clk);
        end
        uvalid = 1'b0;
        do_read(A_STAT, 32'h8000_FFFF, "status_saturated");
        do_read(A_DATA, 32'h0001_0004, "data_last_capture");

        @(negedge clk);
        sel = 1'b1; rnw = 1'b1; abus = A_STAT; be = 4'hF;
        @(negedge clk);
        check("rst_mid_ack_seen", {31'h0, sl_ack}, 32'h1);
        rst = 1'b1;
        #1;
        check("rst_mid_ack_drop", {31'h0, sl_ack}, 32'h0);
        check("rst_mid_dbus", sl_dbus, 32'h0);
        @(negedge clk);
        sel = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        do_read(A_STAT, 32'h0000_0000, "post_rst_status");
        do_read(A_DATA, 32'h0000_0000, "post_rst_data");

        mon_en = 1'b0;
        check("scoreboard_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
